// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: sequences a WIDTH-bit add through one shared external
// 1-bit full-adder cell, LSB first, one bit per clock. Owns the operand, sum
// and carry state and exposes a start/done handshake to the requester.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] s_sh_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // busy_q is high exactly in StRun, so it gates the cell inputs to zero
    // in StIdle/StDone (carry_q still holds the last carry there).
    assign fa_a   = busy_q & a_sh_q[0];
    assign fa_b   = busy_q & b_sh_q[0];
    assign fa_cin = busy_q & carry_q;

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

    // Sequencer: accept in idle, shift one bit per edge in run, pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    s_sh_q  <= {fa_s, s_sh_q[WIDTH-1:1]};
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        // Final bit: publish result straight from the cell.
                        sum_q   <= {fa_s, s_sh_q[WIDTH-1:1]};
                        cout_q  <= fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // start is deliberately ignored here; it is not queued.
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed bench for serial_adder_ctrl (WIDTH=8) with a
// behavioural full-adder cell and a queue scoreboard of expected {cout,sum}.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_s;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_seen = 0;
    int done_cyc = 0;
    int d1 = 0;
    int d2 = 0;
    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .fa_a   (fa_a),
        .fa_b   (fa_b),
        .fa_cin (fa_cin),
        .fa_s   (fa_s),
        .fa_cout(fa_cout),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
    );

    // Combinational full-adder cell shared by the sequencer
    assign fa_s    = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until done is seen (bounded); leaves the bench in the done cycle.
    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check(tag, {31'd0, done}, 32'd1);
        done_cyc = cyc;
    endtask

    // Scoreboard: every done pulse pops one expected result
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                check("result", {23'd0, cout, sum}, {23'd0, e});
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;

        // Asynchronous reset between edges, checked before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {24'd0, sum}, 32'h00);
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        tick();
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();

        // 3 + 5: busy for 8 cycles, done right after edge E0+8
        a = 8'h03; b = 8'h05; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h008);
        tick();
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("busy_run", {31'd0, busy}, 32'd1);
            check("done_low_run", {31'd0, done}, 32'd0);
            tick();
        end
        check("done_at_e8", {31'd0, done}, 32'd1);
        check("busy_at_e8", {31'd0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("fa_idle", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);

        // Full ripple FF + 01: carry 0 on first bit then 1 on the other seven
        a = 8'hFF; b = 8'h01; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h100);
        tick();
        start = 1'b0;
        check("ripple_cin0", {31'd0, fa_cin}, 32'd0);
        check("ripple_ab0", {30'd0, fa_a, fa_b}, 32'd3);
        for (int i = 1; i < W; i++) begin
            tick();
            check("ripple_cin1", {31'd0, fa_cin}, 32'd1);
        end
        wait_done("ripple_done");
        tick();

        // All ones with carry in
        a = 8'hFF; b = 8'hFF; cin = 1'b1; start = 1'b1;
        exp_q.push_back(9'h1FF);
        tick();
        start = 1'b0;
        wait_done("ones_done");
        tick();

        // start held high; operand change mid-run must not disturb op 1
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h030);
        exp_q.push_back(9'h09F);
        tick();
        tick();
        tick();
        a = 8'h7F;
        wait_done("held_done1");
        d1 = done_cyc;
        tick();
        wait_done("held_done2");
        d2 = done_cyc;
        start = 1'b0;
        check("done_period", d2 - d1, 32'd10);
        tick();
        tick();
        check("no_requeue", {31'd0, busy}, 32'd0);

        // Reset during the 4th RUN cycle abandons the operation
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        exp_q.push_back(9'h046);
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_sum", {24'd0, sum}, 32'h00);
        check("mid_rst_cout", {31'd0, cout}, 32'd0);
        check("mid_rst_fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("no_done_after_rst", {31'd0, done}, 32'd0);
        end

        // Post-reset operation: A5 + 5A + 1 = 0x100
        a = 8'hA5; b = 8'h5A; cin = 1'b1; start = 1'b1;
        exp_q.push_back(9'h100);
        tick();
        start = 1'b0;
        wait_done("post_rst_done");
        tick();
        tick();

        check("sb_empty", exp_q.size(), 32'd0);
        check("done_count", done_seen, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
